// File: rtl/gt1_loader_if.sv
// Gigatron GT1 loader bus: HPS ioctl download stream plus the shell hold/RAM/start port.
interface gt1_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        cpu_hold;
  logic        hold_ack;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic [15:0] exec_addr;
  logic        exec_valid;
  logic        load_error;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, hold_ack,
    input  ioctl_wait, cpu_hold, ram_we, ram_addr, ram_data, exec_addr, exec_valid, load_error
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, hold_ack,
    output ioctl_wait, cpu_hold, ram_we, ram_addr, ram_data, exec_addr, exec_valid, load_error
  );
endinterface

// File: rtl/gt1_loader.sv
// Parses a GT1 program stream from the HPS and writes its segments into Gigatron RAM
// while the CPU is held, then reports the start address.
module gt1_loader #(
  parameter logic [7:0] GT1_INDEX = 8'd1
) (
  input logic         clk_sys,
  input logic         reset_n,
  gt1_loader_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StHold, StAddrH, StAddrL, StSize, StData, StStartH, StStartL, StDone, StError
  } state_e;

  state_e      state_q, state_d, st_b;
  logic        sel, sel_q, rise, fall, wr_ok;
  logic [7:0]  seg_hi_q, seg_hi_d, seg_lo_q, seg_lo_d;
  logic [8:0]  count_q, count_d;
  logic        first_q, first_d;
  logic        ram_we_q, ram_we_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic [15:0] exec_addr_q, exec_addr_d;
  logic        exec_valid_q, exec_valid_d;
  logic        load_error_q, load_error_d;

  assign sel   = bus.ioctl_download && (bus.ioctl_index == GT1_INDEX);
  assign rise  = sel && !sel_q;
  assign fall  = !sel && sel_q;
  // A byte strobed on the cycle the download drops still belongs to the stream.
  assign wr_ok = bus.ioctl_wr && (sel || sel_q);

  always_comb begin
    st_b         = state_q;
    seg_hi_d     = seg_hi_q;
    seg_lo_d     = seg_lo_q;
    count_d      = count_q;
    first_d      = first_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    exec_addr_d  = exec_addr_q;
    exec_valid_d = 1'b0;
    load_error_d = load_error_q;

    case (state_q)
      StIdle: begin
        if (rise) begin
          st_b         = StHold;
          load_error_d = 1'b0;
          first_d      = 1'b1;
        end
      end
      StHold:  if (bus.hold_ack) st_b = StAddrH;
      StAddrH: begin
        if (wr_ok) begin
          if (bus.ioctl_dout == 8'h00 && !first_q) begin
            st_b = StStartH;
          end else begin
            seg_hi_d = bus.ioctl_dout;
            st_b     = StAddrL;
          end
        end
      end
      StAddrL: begin
        if (wr_ok) begin
          seg_lo_d = bus.ioctl_dout;
          st_b     = StSize;
        end
      end
      StSize: begin
        if (wr_ok) begin
          count_d = (bus.ioctl_dout == 8'h00) ? 9'd256 : {1'b0, bus.ioctl_dout};
          st_b    = StData;
        end
      end
      StData: begin
        if (wr_ok) begin
          ram_we_d   = 1'b1;
          ram_addr_d = {seg_hi_q, seg_lo_q};
          ram_data_d = bus.ioctl_dout;
          seg_lo_d   = seg_lo_q + 8'd1;
          count_d    = count_q - 9'd1;
          if (count_q == 9'd1) begin
            st_b    = StAddrH;
            first_d = 1'b0;
          end
        end
      end
      StStartH: begin
        if (wr_ok) begin
          exec_addr_d[15:8] = bus.ioctl_dout;
          st_b              = StStartL;
        end
      end
      StStartL: begin
        if (wr_ok) begin
          exec_addr_d[7:0] = bus.ioctl_dout;
          st_b             = StDone;
        end
      end
      StDone:  st_b = StDone;
      StError: st_b = StIdle;
      default: st_b = StIdle;
    endcase

    // The falling edge is judged against the state after this cycle's byte.
    state_d = st_b;
    if (fall) begin
      if (state_q == StHold) begin
        state_d      = StIdle;
        load_error_d = 1'b1;
      end else if (st_b == StAddrH || st_b == StAddrL || st_b == StSize || st_b == StData ||
                   st_b == StStartH || st_b == StStartL) begin
        state_d      = StError;
        load_error_d = 1'b1;
      end else if (st_b == StDone) begin
        state_d      = StIdle;
        exec_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      // Start as if a download were already seen so one in flight at reset must restart.
      sel_q        <= 1'b1;
      seg_hi_q     <= 8'h00;
      seg_lo_q     <= 8'h00;
      count_q      <= 9'd0;
      first_q      <= 1'b1;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 16'h0000;
      ram_data_q   <= 8'h00;
      exec_addr_q  <= 16'h0000;
      exec_valid_q <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel;
      seg_hi_q     <= seg_hi_d;
      seg_lo_q     <= seg_lo_d;
      count_q      <= count_d;
      first_q      <= first_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      exec_addr_q  <= exec_addr_d;
      exec_valid_q <= exec_valid_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.cpu_hold   = (state_q != StIdle) && (state_q != StError);
  assign bus.ioctl_wait = (state_q == StHold) && !bus.hold_ack;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_data   = ram_data_q;
  assign bus.exec_addr  = exec_addr_q;
  assign bus.exec_valid = exec_valid_q;
  assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_gt1_loader.sv
// Directed bench for gt1_loader: GT1 streams with hand-computed RAM writes and start addresses.
module tb_gt1_loader;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          ev_cnt = 0;

  gt1_loader_if bus ();

  gt1_loader #(.GT1_INDEX(8'd1)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (bus.ram_we) begin
      wa.push_back(bus.ram_addr);
      wd.push_back(bus.ram_data);
    end
    if (bus.exec_valid) ev_cnt++;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ev_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_dout = b;
    step();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic begin_download(input int delay);
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    step();
    n_checks++;
    if (bus.cpu_hold !== 1'b1 || bus.ioctl_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_entry: cpu_hold=%b ioctl_wait=%b, want 1 1", bus.cpu_hold, bus.ioctl_wait);
    end
    for (int i = 0; i < delay; i++) begin
      step();
      n_checks++;
      if (bus.ioctl_wait !== 1'b1 || bus.ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_wait[%0d]: ioctl_wait=%b ram_we=%b, want 1 0", i, bus.ioctl_wait,
                 bus.ram_we);
      end
    end
    bus.hold_ack = 1'b1;
    #1;
    n_checks++;
    if (bus.ioctl_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_release: ioctl_wait=%b, want 0", bus.ioctl_wait);
    end
    step();
  endtask

  task automatic end_download_ok(input logic [15:0] exp_exec);
    bus.ioctl_download = 1'b0;
    step();
    n_checks++;
    if (bus.exec_valid !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.exec_addr !== exp_exec) begin
      n_fail++;
      $display("FAIL finish: exec_valid=%b cpu_hold=%b exec_addr=%h, want 1 0 %h",
               bus.exec_valid, bus.cpu_hold, bus.exec_addr, exp_exec);
    end
    bus.hold_ack = 1'b0;
    step();
    n_checks++;
    if (bus.exec_valid !== 1'b0 || ev_cnt != 1 || bus.load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse: exec_valid=%b pulses=%0d load_error=%b, want 0 1 0", bus.exec_valid,
               ev_cnt, bus.load_error);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    n_checks++;
    if ({bus.cpu_hold, bus.ioctl_wait, bus.ram_we, bus.exec_valid, bus.load_error} !== 5'b0 ||
        bus.ram_addr !== 16'h0 || bus.ram_data !== 8'h0 || bus.exec_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: hold=%b wait=%b we=%b ev=%b err=%b addr=%h data=%h exec=%h",
               bus.cpu_hold, bus.ioctl_wait, bus.ram_we, bus.exec_valid, bus.load_error,
               bus.ram_addr, bus.ram_data, bus.exec_addr);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] s[9] = '{8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h02, 8'h00};
    clear_log();
    begin_download(0);
    foreach (s[i]) send_byte(s[i]);
    step();
    n_checks++;
    if (wa.size() != 3 || wa[0] !== 16'h0200 || wd[0] !== 8'hAA || wa[1] !== 16'h0201 ||
        wd[1] !== 8'hBB || wa[2] !== 16'h0202 || wd[2] !== 8'hCC) begin
      n_fail++;
      $display("FAIL basic_writes: count=%0d, want 3 writes 0200=AA 0201=BB 0202=CC", wa.size());
    end
    n_checks++;
    if (bus.cpu_hold !== 1'b1 || bus.exec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_hold: cpu_hold=%b exec_valid=%b, want 1 0", bus.cpu_hold,
               bus.exec_valid);
    end
    end_download_ok(16'h0200);
  endtask

  task automatic test_page_wrap();
    logic [7:0] s[9] = '{8'h05, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00, 8'h80, 8'h00};
    clear_log();
    begin_download(0);
    foreach (s[i]) send_byte(s[i]);
    n_checks++;
    if (wa.size() != 3 || wa[0] !== 16'h05FE || wa[1] !== 16'h05FF || wa[2] !== 16'h0500 ||
        wd[2] !== 8'h33) begin
      n_fail++;
      $display("FAIL page_wrap: count=%0d last=%h, want 3 writes ending 0500=33", wa.size(),
               (wa.size() > 0) ? wa[wa.size()-1] : 16'hxxxx);
    end
    end_download_ok(16'h8000);
  endtask

  task automatic test_zero_page();
    logic [7:0] s[8] = '{8'h00, 8'h30, 8'h02, 8'h01, 8'h02, 8'h00, 8'h12, 8'h34};
    clear_log();
    begin_download(0);
    foreach (s[i]) send_byte(s[i]);
    n_checks++;
    if (wa.size() != 2 || wa[0] !== 16'h0030 || wd[0] !== 8'h01 || wa[1] !== 16'h0031 ||
        wd[1] !== 8'h02) begin
      n_fail++;
      $display("FAIL zero_page: count=%0d, want 0030=01 0031=02", wa.size());
    end
    end_download_ok(16'h1234);
  endtask

  task automatic test_size_256();
    int bad = 0;
    clear_log();
    begin_download(0);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i ^ 8'h5A));
    send_byte(8'h30);
    send_byte(8'h40);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h00);
    send_byte(8'hAB);
    send_byte(8'hCD);
    n_checks++;
    if (wa.size() != 257) begin
      n_fail++;
      $display("FAIL size256_count: got %0d writes, want 257", wa.size());
    end else begin
      for (int i = 0; i < 256; i++)
        if (wa[i] !== {8'h20, 8'(i)} || wd[i] !== 8'(i ^ 8'h5A)) bad++;
      if (bad != 0 || wa[255] !== 16'h20FF || wa[256] !== 16'h3040 || wd[256] !== 8'h55) begin
        n_fail++;
        $display("FAIL size256_data: %0d bad, last=%h next=%h, want 0 20FF 3040", bad, wa[255],
                 wa[256]);
      end
    end
    end_download_ok(16'hABCD);
  endtask

  task automatic test_abort();
    logic [7:0] s[5] = '{8'h01, 8'h00, 8'h03, 8'hA1, 8'hA2};
    clear_log();
    begin_download(10);
    foreach (s[i]) send_byte(s[i]);
    bus.ioctl_download = 1'b0;
    step();
    n_checks++;
    if (bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.exec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: load_error=%b cpu_hold=%b exec_valid=%b, want 1 0 0",
               bus.load_error, bus.cpu_hold, bus.exec_valid);
    end
    bus.hold_ack = 1'b0;
    repeat (3) step();
    n_checks++;
    if (wa.size() != 2 || ev_cnt != 0 || bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: writes=%0d pulses=%0d load_error=%b, want 2 0 1", wa.size(),
               ev_cnt, bus.load_error);
    end
    // Next download clears the sticky error and completes normally.
    clear_log();
    begin_download(0);
    n_checks++;
    if (bus.load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: load_error=%b, want 0", bus.load_error);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    end_download_ok(16'h0000);
  endtask

  task automatic test_hold_drop();
    clear_log();
    bus.ioctl_download = 1'b1;
    step();
    bus.ioctl_download = 1'b0;
    step();
    n_checks++;
    if (bus.cpu_hold !== 1'b0 || bus.load_error !== 1'b1 || bus.ioctl_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drop: cpu_hold=%b load_error=%b ioctl_wait=%b, want 0 1 0",
               bus.cpu_hold, bus.load_error, bus.ioctl_wait);
    end
    step();
    n_checks++;
    if (ev_cnt != 0) begin
      n_fail++;
      $display("FAIL hold_drop_pulse: pulses=%0d, want 0", ev_cnt);
    end
  endtask

  task automatic test_other_index();
    int held = 0;
    clear_log();
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i + 1));
      if (bus.cpu_hold !== 1'b0) held++;
    end
    bus.ioctl_download = 1'b0;
    step();
    bus.ioctl_index = 8'd1;
    step();
    n_checks++;
    if (held != 0 || wa.size() != 0 || ev_cnt != 0) begin
      n_fail++;
      $display("FAIL other_index: hold cycles=%0d writes=%0d pulses=%0d, want 0 0 0", held,
               wa.size(), ev_cnt);
    end
  endtask

  task automatic test_wr_on_fall();
    logic [7:0] s[6] = '{8'h00, 8'h60, 8'h01, 8'h99, 8'h00, 8'h56};
    clear_log();
    begin_download(0);
    foreach (s[i]) send_byte(s[i]);
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_dout     = 8'h78;
    bus.ioctl_download = 1'b0;
    step();
    bus.ioctl_wr = 1'b0;
    n_checks++;
    if (bus.exec_valid !== 1'b1 || bus.exec_addr !== 16'h5678 || bus.load_error !== 1'b0 ||
        bus.cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_on_fall: exec_valid=%b exec_addr=%h load_error=%b hold=%b, want 1 5678 0 0",
               bus.exec_valid, bus.exec_addr, bus.load_error, bus.cpu_hold);
    end
    bus.hold_ack = 1'b0;
    step();
    n_checks++;
    if (wa.size() != 1 || wa[0] !== 16'h0060 || wd[0] !== 8'h99 || ev_cnt != 1) begin
      n_fail++;
      $display("FAIL wr_on_fall_log: writes=%0d pulses=%0d, want 1 1", wa.size(), ev_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[5] = '{8'h04, 8'h00, 8'h05, 8'h01, 8'h02};
    int held = 0;
    clear_log();
    begin_download(0);
    foreach (s[i]) send_byte(s[i]);
    reset_n      = 1'b0;
    bus.hold_ack = 1'b0;
    #1;
    n_checks++;
    if ({bus.cpu_hold, bus.ioctl_wait, bus.ram_we, bus.exec_valid, bus.load_error} !== 5'b0 ||
        bus.ram_addr !== 16'h0 || bus.ram_data !== 8'h0 || bus.exec_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: hold=%b wait=%b we=%b ev=%b err=%b addr=%h data=%h exec=%h",
               bus.cpu_hold, bus.ioctl_wait, bus.ram_we, bus.exec_valid, bus.load_error,
               bus.ram_addr, bus.ram_data, bus.exec_addr);
    end
    step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'h03 + i));
      if (bus.cpu_hold !== 1'b0) held++;
    end
    bus.ioctl_download = 1'b0;
    step();
    n_checks++;
    if (held != 0 || wa.size() != 1 || wa[0] !== 16'h0400) begin
      n_fail++;
      $display("FAIL reset_no_restart: hold cycles=%0d writes=%0d, want 0 1", held, wa.size());
    end
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd1;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_dout     = 8'h00;
    bus.hold_ack       = 1'b0;
    test_reset();
    test_basic();
    test_page_wrap();
    test_zero_page();
    test_size_256();
    test_abort();
    test_hold_drop();
    test_other_index();
    test_wr_on_fall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gt1_loader.md
GT1_LOADER -- requirements
Module: gt1_loader

Interface
REQ-001 SHALL have parameter GT1_INDEX, default 8'd1, the ioctl_index value that selects a GT1 program download.
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports ioctl_download  input  1  download active; ioctl_index  input  8  download type; ioctl_wr  input  1  byte strobe; ioctl_dout  input  8  byte from the HPS.
REQ-005 SHALL have port ioctl_wait  output  1  stall request to the HPS.
REQ-006 SHALL have ports cpu_hold  output  1  halt request to the Gigatron shell; hold_ack  input  1  Gigatron halted, RAM port owned by the loader.
REQ-007 SHALL have ports ram_we  output  1; ram_addr  output  16; ram_data  output  8; together they form the Gigatron RAM write port.
REQ-008 SHALL have ports exec_addr  output  16  program start address; exec_valid  output  1  one-cycle start pulse; load_error  output  1  sticky error flag.

Function
REQ-009 SHALL consider a download selected when ioctl_download=1 and ioctl_index==GT1_INDEX; it SHALL ignore ioctl_wr when no download is selected.
REQ-010 SHALL implement the states IDLE, HOLD, ADDR_H, ADDR_L, SIZE, DATA, START_H, START_L, DONE and ERROR.
REQ-011 IDLE->HOLD on a selected-download rising edge; in HOLD: cpu_hold=1, ioctl_wait=1; HOLD->ADDR_H the cycle after hold_ack=1.
REQ-012 SHALL keep cpu_hold=1 in every state from HOLD up to and including DONE/ERROR entry, and SHALL deassert ioctl_wait the cycle hold_ack is sampled high.
REQ-013 SHALL consume exactly one byte per ioctl_wr=1 cycle outside HOLD, with no back-pressure after HOLD.
REQ-014 ADDR_H: the byte is stored as seg_hi, then ->ADDR_L; exception: if the byte is 0x00 and this is not the first segment, ->START_H.
REQ-015 ADDR_L: the byte is stored as seg_lo, then ->SIZE.
REQ-016 SIZE: the byte is loaded as count, where 0x00 means 256 (9-bit counter), then ->DATA.
REQ-017 DATA: each byte SHALL produce ram_we=1 for exactly one cycle, with ram_addr={seg_hi,seg_lo} and ram_data=byte, the cycle after the ioctl_wr sample.
REQ-018 DATA: after each write, seg_lo SHALL increment mod 256 and seg_hi SHALL be unchanged (in-page wrap); count SHALL decrement; at count==0 the state SHALL go ->ADDR_H with first-segment cleared.
REQ-019 START_H and START_L: the bytes SHALL be latched as exec_addr[15:8] and exec_addr[7:0], then ->DONE.
REQ-020 DONE: bytes after the terminator SHALL be ignored; on the selected download falling edge, exec_valid=1 for one cycle, cpu_hold=0 the same cycle, ->IDLE.
REQ-021 Download falling edge in any state ADDR_H..START_L: ->ERROR, load_error=1, cpu_hold=0 next cycle, exec_valid stays 0, ->IDLE.
REQ-022 Download falling edge during HOLD: ->IDLE, cpu_hold=0, load_error=1.
REQ-023 load_error SHALL clear only on the next selected-download start or on reset.
REQ-024 SHALL not change ram_addr or ram_data while ram_we=0 in any state other than DATA.
REQ-025 If ioctl_wr coincides with the download falling edge, SHALL process the byte first, then evaluate the edge.

Reset
REQ-026 With reset_n=0: state=IDLE, cpu_hold=0, ioctl_wait=0, ram_we=0, ram_addr=0, ram_data=0, exec_addr=0, exec_valid=0, load_error=0, first-segment=1, count=0.
REQ-027 Reset mid-download SHALL abort with no further RAM writes; the loader SHALL wait for a fresh selected-download rising edge.

Verification
REQ-028 Stream 02 00 03 AA BB CC 00 02 00, then download drop -> writes 0x0200=AA, 0x0201=BB, 0x0202=CC; exec_addr=0x0200; one exec_valid pulse; cpu_hold falls the same cycle.
REQ-029 Segment 05 FE 03 11 22 33 -> writes 0x05FE, 0x05FF, 0x0500 (in-page wrap); no write to 0x0600.
REQ-030 First segment 00 30 02 01 02, then 00 12 34 -> zero-page writes 0x0030, 0x0031; then terminator; exec_addr=0x1234.
REQ-031 Size byte 00 followed by 256 bytes -> exactly 256 ram_we pulses, the last at 0xXXFF wrap position; the next byte is parsed as ADDR_H.
REQ-032 hold_ack delayed 10 cycles -> ioctl_wait=1 for those cycles and no ram_we; download drop after 2 of 3 data bytes -> load_error=1, no exec_valid, cpu_hold=0.
REQ-033 ioctl_index=0 download -> no cpu_hold, no ram_we; reset_n pulse mid-DATA -> all outputs at reset values at once.
